// File: rtl/drec_pkg.sv
// Shared definitions for the PWM data-recorder blocks: frame timing,
// sample width and the FIFO word layout used by both pwmdac and pwm_capture.
package drec_pkg;

    localparam int PWM_PERIOD = 256;
    localparam int PWM_SLACK  = 16;
    localparam int SAMPLE_W   = 8;
    localparam int WORD_W     = 16;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } cap_state_e;

    // The PWM adapter reads the sample from bits [11:4] of the FIFO word.
    function automatic logic [WORD_W-1:0] pack_sample(input logic [SAMPLE_W-1:0] s);
        return {4'b0000, s, 4'b0000};
    endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// FIFO write port between the PWM capture block (master) and the sample FIFO (slave).
interface pwm_capture_if;
    import drec_pkg::*;

    logic [WORD_W-1:0] wr_data;
    logic              wr;
    logic              full;

    modport master (output wr_data, output wr, input full);
    modport slave  (input wr_data, input wr, output full);

endinterface

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for the asynchronous PWM line plus registered rising-edge
// detect; level and rise leave the block aligned to the same cycle.
module pwm_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [1:0] sync_q, sync_d;
    logic       level_q, level_d;
    logic       rise_q, rise_d;

    always_comb begin
        sync_d  = {sync_q[0], async_in};
        level_d = sync_q[1];
        rise_d  = sync_q[1] & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures the high time of each PWM frame on pwm_in and writes it to a FIFO as an
// 8-bit sample; flags short frames and samples dropped on a full FIFO.
module pwm_capture
    import drec_pkg::*;
#(
    parameter int PERIOD = PWM_PERIOD,
    parameter int SLACK  = PWM_SLACK
) (
    input  logic          pwmclk,
    input  logic          RESET,
    input  logic          pwm_in,
    input  logic          enable,
    pwm_capture_if.master fifo,
    output logic          overrun,
    output logic          frame_err
);

    localparam int CNT_W = $clog2(PERIOD + SLACK) + 1;
    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(PERIOD - SLACK);
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(PERIOD + SLACK);

    function automatic logic [SAMPLE_W-1:0] sat_inc(input logic [SAMPLE_W-1:0] v);
        return (&v) ? v : v + SAMPLE_W'(1);
    endfunction

    logic level, rise;

    pwm_sync_edge u_sync (
        .clk      (pwmclk),
        .rst_n    (RESET),
        .async_in (pwm_in),
        .level    (level),
        .rise     (rise)
    );

    cap_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] hi_q, hi_d;
    logic                wr_q, wr_d;
    logic [WORD_W-1:0]   wr_data_q, wr_data_d;
    logic                overrun_q, overrun_d;
    logic                frame_err_q, frame_err_d;
    logic                emit;
    logic [SAMPLE_W-1:0] emit_val;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        wr_d        = 1'b0;
        wr_data_d   = wr_data_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        emit        = 1'b0;
        emit_val    = '0;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            hi_d    = '0;
        end else if (state_q == ST_IDLE) begin
            // The edge cycle is already the first cycle of the frame being measured.
            if (rise) begin
                state_d = ST_MEASURE;
                cnt_d   = CNT_W'(1);
                hi_d    = SAMPLE_W'(1);
            end
        end else if (rise) begin
            if (cnt_q >= MIN_LEN) begin
                emit     = 1'b1;
                emit_val = hi_q;
            end else begin
                frame_err_d = 1'b1;
            end
            cnt_d = CNT_W'(1);
            hi_d  = SAMPLE_W'(1);
        end else if (cnt_q >= MAX_LEN) begin
            // No edge for a whole tolerance window: the line is stuck at 0% or 100%.
            emit     = 1'b1;
            emit_val = {SAMPLE_W{level}};
            cnt_d    = CNT_W'(1);
            hi_d     = {{(SAMPLE_W-1){1'b0}}, level};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            hi_d  = level ? sat_inc(hi_q) : hi_q;
        end

        if (emit) begin
            if (fifo.full) begin
                overrun_d = 1'b1;
            end else begin
                wr_d      = 1'b1;
                wr_data_d = pack_sample(emit_val);
            end
        end
    end

    always_ff @(posedge pwmclk) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            wr_q        <= 1'b0;
            wr_data_q   <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            wr_q        <= wr_d;
            wr_data_q   <= wr_data_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign fifo.wr      = wr_q;
    assign fifo.wr_data = wr_data_q;
    assign overrun      = overrun_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed frame scenarios with literal expectations plus
// randomized frames, all outputs compared every cycle against a frame-level model.
module tb_pwm_capture;
    import drec_pkg::*;

    localparam int PER     = 256;
    localparam int SLK     = 16;
    localparam int MIN_LEN = PER - SLK;
    localparam int MAX_LEN = PER + SLK;
    localparam int LAT     = 3;

    logic pwmclk = 1'b0;
    logic RESET  = 1'b0;
    logic pwm_in = 1'b0;
    logic enable = 1'b0;
    logic full   = 1'b0;
    logic overrun, frame_err;

    pwm_capture_if fifo_if ();
    assign fifo_if.full = full;

    pwm_capture #(.PERIOD(PER), .SLACK(SLK)) dut (
        .pwmclk    (pwmclk),
        .RESET     (RESET),
        .pwm_in    (pwm_in),
        .enable    (enable),
        .fifo      (fifo_if),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 pwmclk = ~pwmclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    // hist[n] is the pwm_in value sampled at clock edge n. A decision taken at
    // edge m looks at sample m-LAT; a frame is the run of samples from one
    // rising edge (inclusive) to the next (exclusive).
    bit          hist[$];
    bit          m_meas  = 1'b0;
    int          m_start = 0;
    logic        m_wr    = 1'b0;
    logic [15:0] m_data  = 16'h0000;
    logic        m_ovr   = 1'b0;
    logic        m_ferr  = 1'b0;

    function automatic bit smp(input int j);
        return (j >= 0 && j < hist.size()) ? hist[j] : 1'b0;
    endfunction

    function automatic logic [7:0] high_time(input int a, input int b);
        int s = 0;
        for (int i = a; i < b; i++) s += int'(smp(i));
        return (s > 255) ? 8'hFF : 8'(s);
    endfunction

    initial begin : model
        int m, j, len;
        bit have;
        logic [7:0] val;
        forever begin
            @(posedge pwmclk);
            hist.push_back(pwm_in);
            m    = hist.size() - 1;
            m_wr = 1'b0;
            if (!RESET) begin
                // synchronizer contents are lost: the last samples read as low
                for (int k = 0; k < LAT; k++) if (m - k >= 0) hist[m-k] = 1'b0;
                m_meas = 1'b0;
                m_data = 16'h0000;
                m_ovr  = 1'b0;
                m_ferr = 1'b0;
            end else begin
                j = m - LAT;
                if (!enable) begin
                    m_meas = 1'b0;
                end else if (!m_meas) begin
                    if (smp(j) && !smp(j-1)) begin
                        m_meas  = 1'b1;
                        m_start = j;
                    end
                end else begin
                    len  = j - m_start;
                    have = 1'b0;
                    val  = 8'h00;
                    if (smp(j) && !smp(j-1)) begin
                        if (len >= MIN_LEN) begin
                            have = 1'b1;
                            val  = high_time(m_start, j);
                        end else begin
                            m_ferr = 1'b1;
                        end
                        m_start = j;
                    end else if (len >= MAX_LEN) begin
                        have    = 1'b1;
                        val     = smp(j) ? 8'hFF : 8'h00;
                        m_start = j;
                    end
                    if (have) begin
                        if (full) m_ovr = 1'b1;
                        else begin
                            m_wr   = 1'b1;
                            m_data = {4'h0, val, 4'h0};
                        end
                    end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge pwmclk);
            check("cycle_outputs{wr,wr_data,overrun,frame_err}",
                  {fifo_if.wr, fifo_if.wr_data, overrun, frame_err},
                  {m_wr, m_data, m_ovr, m_ferr});
        end
    end

    // Write-strobe bookkeeping for the directed checks.
    int wr_seen = 0;
    int cyc     = 0;
    int wr_cyc[$];

    initial begin : monitor
        forever begin
            @(posedge pwmclk);
            cyc++;
            if (fifo_if.wr === 1'b1) begin
                wr_seen++;
                wr_cyc.push_back(cyc);
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = v;
            @(negedge pwmclk);
        end
    endtask

    task automatic do_reset();
        pwm_in = 1'b0;
        RESET  = 1'b0;
        repeat (2) @(negedge pwmclk);
        RESET  = 1'b1;
    endtask

    task automatic frame(input int hi, input int len, input bit lat = 1'b0,
                         input int en_drop_at = -1, input int rst_at = -1);
        for (int i = 0; i < len; i++) begin
            pwm_in = (i < hi);
            enable = (i != en_drop_at);
            RESET  = (i != rst_at);
            @(negedge pwmclk);
            if (lat && i <= LAT) check("edge_to_wr_latency", fifo_if.wr, (i == LAT));
            if (i == rst_at)
                check("reset_mid_frame_outputs", {fifo_if.wr, fifo_if.wr_data, overrun, frame_err}, 0);
        end
        enable = 1'b1;
        RESET  = 1'b1;
    endtask

    initial begin : stim
        int w0, len, hi, r, ed, rs;

        repeat (3) @(negedge pwmclk);
        check("reset_state", {fifo_if.wr, fifo_if.wr_data, overrun, frame_err}, 0);
        RESET  = 1'b1;
        enable = 1'b1;

        // steady 64/192 frames
        w0 = wr_seen;
        frame(64, 256); frame(64, 256); frame(64, 256, 1'b1); frame(64, 256);
        check("steady_wr_count", wr_seen - w0, 3);
        check("steady_wr_data", fifo_if.wr_data, 16'h0400);

        // line held low after the last edge: timeouts every MAX_LEN cycles
        wr_cyc.delete();
        drive(1'b0, 900);
        check("timeout_low_count", wr_cyc.size(), 4);
        if (wr_cyc.size() >= 3) begin
            check("timeout_low_interval1", wr_cyc[1] - wr_cyc[0], 272);
            check("timeout_low_interval2", wr_cyc[2] - wr_cyc[1], 272);
        end
        check("timeout_low_data", fifo_if.wr_data, 16'h0000);
        check("timeout_low_no_frame_err", frame_err, 1'b0);

        // line held high after one edge
        do_reset();
        wr_cyc.delete();
        drive(1'b1, 700);
        check("timeout_high_count", wr_cyc.size(), 2);
        if (wr_cyc.size() >= 2) check("timeout_high_interval", wr_cyc[1] - wr_cyc[0], 272);
        check("timeout_high_data", fifo_if.wr_data, 16'h0FF0);

        // 255/1 duty and high-time saturation
        do_reset();
        frame(255, 256); frame(255, 256); frame(255, 256);
        check("duty_255_data", fifo_if.wr_data, 16'h0FF0);
        frame(64, 256); frame(269, 270);
        check("before_saturation_data", fifo_if.wr_data, 16'h0400);
        frame(64, 256);
        check("saturated_high_time_data", fifo_if.wr_data, 16'h0FF0);

        // FIFO full during the emission of 0x80
        do_reset();
        frame(64, 256); frame(128, 256);
        w0   = wr_seen;
        full = 1'b1;
        frame(128, 256);
        full = 1'b0;
        check("full_no_wr", wr_seen - w0, 0);
        check("full_data_held", fifo_if.wr_data, 16'h0400);
        check("full_overrun_set", overrun, 1'b1);
        frame(64, 256);
        check("overrun_sticky", overrun, 1'b1);
        check("after_full_data", fifo_if.wr_data, 16'h0800);

        // glitch edge 100 cycles into a frame
        do_reset();
        frame(64, 256); frame(64, 100);
        w0 = wr_seen;
        frame(64, 256);
        check("glitch_no_wr", wr_seen - w0, 0);
        check("glitch_frame_err", frame_err, 1'b1);
        frame(64, 256);
        check("after_glitch_wr", wr_seen - w0, 1);
        check("after_glitch_data", fifo_if.wr_data, 16'h0400);

        // reset pulsed 120 cycles into a frame
        do_reset();
        frame(64, 256); frame(64, 256);
        frame(64, 256, 1'b0, -1, 120);
        w0 = wr_seen;
        frame(64, 256);
        check("post_reset_first_edge_no_wr", wr_seen - w0, 0);
        check("post_reset_data_zero", fifo_if.wr_data, 16'h0000);
        frame(64, 256);
        check("post_reset_second_edge_wr", wr_seen - w0, 1);
        check("post_reset_frame_err_clear", frame_err, 1'b0);

        // enable dropped mid-frame
        frame(64, 256, 1'b0, 120, -1);
        w0 = wr_seen;
        frame(64, 256);
        check("enable_drop_no_wr", wr_seen - w0, 0);
        frame(64, 256);
        check("enable_restart_wr", wr_seen - w0, 1);

        // randomized frames: lengths valid, short and over-long; random full, enable drops, resets
        do_reset();
        for (int f = 0; f < 40; f++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)      len = int'($urandom_range(MIN_LEN, MAX_LEN - 1));
            else if (r < 8) len = int'($urandom_range(40, MIN_LEN - 1));
            else            len = int'($urandom_range(MAX_LEN, MAX_LEN + 60));
            hi   = int'($urandom_range(1, len - 1));
            full = ($urandom_range(0, 6) == 0);
            ed   = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            rs   = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            frame(hi, len, 1'b0, ed, rs);
        end
        full = 1'b0;
        drive(1'b0, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
